// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that shares one iterative sqrt engine among NREQ requesters.
// The result follows engine done by one cycle; it is held until resp_ready, and requests wait while busy.
module sqrt_arbiter #(
   parameter int NREQ     = 4,
   parameter int TIMEOUT  = 24,
   localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_x,
   output logic [NREQ-1:0]      req_ready,
   output logic                 resp_valid,
   output logic [IDW-1:0]       resp_id,
   output logic [15:0]          resp_root,
   output logic                 resp_err,
   input  logic                 resp_ready,
   output logic                 eng_start,
   output logic [31:0]          eng_x,
   input  logic                 eng_rdy,
   input  logic [15:0]          eng_root,
   output logic                 busy,
   output logic                 err_sticky
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [31:0]     x_reg;
   logic [IDW-1:0]  id_reg;
   logic [IDW-1:0]  last_grant;
   logic [CW-1:0]   cnt;
   logic [15:0]     root_reg;
   logic            err_reg;

   logic            grant_vld;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  cand;
   logic [31:0]     x_sel;
   logic            timeout_hit;

   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

   // Search begins one past the last winner so every requester gets a turn.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_grant) + k) % NREQ);
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      x_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant_idx == IDW'(k)) x_sel = req_x[32*k +: 32];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      eng_start  = 1'b0;
      resp_valid = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            // Gated by reset so nothing is offered while reset is held.
            if (grant_vld && !reset) req_ready = NREQ'(1) << grant_idx;
            if (grant_vld) state_nxt = START;
         end
         START: begin
            eng_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (eng_rdy || timeout_hit) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_reg      <= '0;
         id_reg     <= '0;
         last_grant <= IDW'(NREQ - 1);
         cnt        <= '0;
         root_reg   <= '0;
         err_reg    <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  x_reg      <= x_sel;
                  id_reg     <= grant_idx;
                  last_grant <= grant_idx;
               end
            end
            START: cnt <= '0;
            WAIT: begin
               // A done flag in the timeout cycle still counts as a good result.
               if (eng_rdy) begin
                  root_reg <= eng_root;
                  err_reg  <= 1'b0;
               end else if (timeout_hit) begin
                  root_reg   <= '0;
                  err_reg    <= 1'b1;
                  err_sticky <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign eng_x     = x_reg;
   assign resp_id   = id_reg;
   assign resp_root = root_reg;
   assign resp_err  = err_reg;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural engine, timestamp-based reference model checked every cycle,
// plus directed transactions with hand-computed results.
module tb_sqrt_arbiter;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 24;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [32*NREQ-1:0]  req_x;
   logic [NREQ-1:0]     req_ready;
   logic                resp_valid;
   logic [1:0]          resp_id;
   logic [15:0]         resp_root;
   logic                resp_err;
   logic                resp_ready;
   logic                eng_start;
   logic [31:0]         eng_x;
   logic                eng_rdy  = 1'b1;
   logic [15:0]         eng_root = 16'h1234;
   logic                busy;
   logic                err_sticky;

   int checks = 0;
   int errors = 0;
   int eng_lat = 16;
   int ecnt = 0;
   bit eclr = 1'b0;

   sqrt_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_x      (req_x),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_root  (resp_root),
      .resp_err   (resp_err),
      .resp_ready (resp_ready),
      .eng_start  (eng_start),
      .eng_x      (eng_x),
      .eng_rdy    (eng_rdy),
      .eng_root   (eng_root),
      .busy       (busy),
      .err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] isqrt(input logic [31:0] x);
      longint lo, hi, mid;
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= longint'(x)) lo = mid;
         else hi = mid - 1;
      end
      return 16'(lo);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Engine: restarted by eng_start, done flag stays high (stale) until one cycle after restart.
   always @(negedge clk) begin
      if (eng_start) begin
         ecnt = 0;
         eclr = 1'b1;
      end else begin
         if (eclr) begin
            eng_rdy = 1'b0;
            eclr    = 1'b0;
         end
         ecnt++;
         if (ecnt == eng_lat) begin
            eng_rdy  = 1'b1;
            eng_root = isqrt(eng_x);
         end
      end
   end

   // Reference model: one outstanding op described by its start and response cycle numbers.
   bit          m_active = 1'b0;
   int          m_id, m_last = NREQ - 1, m_start, m_resp, cyc = 0;
   logic [31:0] m_x;
   logic [15:0] m_root;
   bit          m_err, m_sticky = 1'b0;

   always @(negedge clk) begin
      int g;
      int c;
      logic [NREQ-1:0] exp_ready;
      cyc++;
      if (reset) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_resp_id", resp_id, 0);
         chk("rst_resp_root", resp_root, 0);
         chk("rst_resp_err", resp_err, 0);
         chk("rst_eng_start", eng_start, 0);
         chk("rst_eng_x", eng_x, 0);
         chk("rst_busy", busy, 0);
         chk("rst_err_sticky", err_sticky, 0);
         m_active = 1'b0;
         m_last   = NREQ - 1;
         m_sticky = 1'b0;
      end else begin
         g = -1;
         if (!m_active) begin
            for (int k = 1; k <= NREQ; k++) begin
               c = (m_last + k) % NREQ;
               if (g < 0 && req_valid[c]) g = c;
            end
         end
         exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
         chk("m_req_ready", req_ready, exp_ready);
         chk("m_busy", busy, m_active);
         chk("m_eng_start", eng_start, m_active && cyc == m_start);
         chk("m_resp_valid", resp_valid, m_active && cyc >= m_resp);
         chk("m_err_sticky", err_sticky, m_sticky);
         if (m_active && cyc >= m_resp) begin
            chk("m_resp_id", resp_id, m_id);
            chk("m_resp_root", resp_root, m_root);
            chk("m_resp_err", resp_err, m_err);
         end
         if (m_active && cyc < m_resp) chk("m_eng_x", eng_x, m_x);

         if (!m_active && g >= 0) begin
            m_active = 1'b1;
            m_id     = g;
            m_last   = g;
            m_x      = req_x[32*g +: 32];
            m_start  = cyc + 1;
            m_err    = (eng_lat > TIMEOUT);
            m_resp   = m_start + (m_err ? TIMEOUT : eng_lat) + 1;
            m_root   = m_err ? 16'd0 : isqrt(m_x);
         end else if (m_active) begin
            if (m_err && cyc + 1 == m_resp) m_sticky = 1'b1;
            if (cyc >= m_resp && resp_ready) m_active = 1'b0;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after the response handshake.
   task automatic op(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] after, input int lat,
                     input int exp_id, input logic [15:0] exp_root, input logic exp_err, input int hold);
      int n, t_start, t_resp;
      bit seen;
      eng_lat    = lat;
      req_valid  = mask;
      resp_ready = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 50) begin
         @(negedge clk);
         n++;
         if (req_ready != '0) seen = 1'b1;
      end
      chk("grant_onehot", req_ready, NREQ'(1) << exp_id);
      @(posedge clk); #1;
      req_valid = after;
      seen = 1'b0;
      n = 0;
      t_start = -1;
      t_resp = -1;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (eng_start) t_start = n;
         if (resp_valid) begin
            seen = 1'b1;
            t_resp = n;
         end
      end
      chk("resp_seen", seen, 1);
      chk("resp_id", resp_id, exp_id);
      chk("resp_root", resp_root, exp_root);
      chk("resp_err", resp_err, exp_err);
      chk("resp_latency", t_resp - t_start, (lat <= TIMEOUT) ? lat + 1 : TIMEOUT + 1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_valid", resp_valid, 1);
         chk("bp_id", resp_id, exp_id);
         chk("bp_root", resp_root, exp_root);
         chk("bp_req_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_x      = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Round robin with constant requests; lanes carry the boundary radicands.
      req_x = {32'd1000000, 32'd15, 32'hFFFF_FFFF, 32'd0};
      op(4'b1111, 4'b1111, 1,       0, 16'd0,     1'b0, 0);
      op(4'b1111, 4'b1111, 5,       1, 16'd65535, 1'b0, 0);
      op(4'b1111, 4'b1111, TIMEOUT, 2, 16'd3,     1'b0, 0);
      op(4'b1111, 4'b1111, 16,      3, 16'd1000,  1'b0, 0);
      op(4'b1111, 4'b0000, 3,       0, 16'd0,     1'b0, 2);

      // Single request.
      req_x = {32'd1000000, 32'd15, 32'hFFFF_FFFF, 32'd1000000};
      op(4'b0001, 4'b0000, 16, 0, 16'd1000, 1'b0, 0);

      // Back-pressure with requester 0 waiting throughout.
      op(4'b0100, 4'b0001, 8, 2, 16'd3, 1'b0, 10);

      // Timeout, then a normal op; the sticky flag must survive.
      op(4'b1001, 4'b0001, 1000, 3, 16'd0, 1'b1, 0);
      chk("sticky_after_timeout", err_sticky, 1);
      op(4'b0001, 4'b0000, 16, 0, 16'd1000, 1'b0, 0);
      chk("sticky_after_normal", err_sticky, 1);

      // Reset five cycles after START abandons the op.
      eng_lat   = 16;
      req_valid = 4'b0001;
      @(negedge clk);
      chk("rw_grant", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      repeat (5) @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = 4'b0010;
      @(negedge clk);
      chk("rw_no_resp", resp_valid, 0);
      chk("rw_sticky_clear", err_sticky, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      op(4'b0010, 4'b0000, 4, 1, 16'd65535, 1'b0, 0);

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one iterative 32-bit square-root engine.
REQ-002 Parameter TIMEOUT, 24, maximum WAIT cycles before the engine is declared hung.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request strobe, held until accepted.
REQ-006 req_x  input  32*NREQ  radicand; requester i occupies bits [32*i+31:32*i].
REQ-007 req_ready  output  NREQ  one-hot accept; at most one bit high per cycle.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_id  output  log2(NREQ)  index of the requester owning the result.
REQ-010 resp_root  output  16  floor(sqrt(x)) for the accepted radicand.
REQ-011 resp_err  output  1  result invalid because of a timeout; qualified by resp_valid.
REQ-012 resp_ready  input  1  consumer accepts the result.
REQ-013 eng_start  output  1  engine restart pulse (drives the engine's active-high reset).
REQ-014 eng_x  output  32  radicand presented to the engine.
REQ-015 eng_rdy  input  1  engine done flag.
REQ-016 eng_root  input  16  engine result.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 err_sticky  output  1  set on any timeout; cleared only by reset.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, START, WAIT, RESP.
REQ-020 IDLE: round-robin grant among the asserted req_valid bits, with the search starting at last_grant+1 mod NREQ; req_ready[g] high combinationally for the granted g only.
REQ-021 IDLE with no req_valid SHALL keep req_ready all-zero and stay in IDLE.
REQ-022 On an accept (req_valid[g] & req_ready[g]), the block SHALL latch x_reg=req_x[g] and id_reg=g, set last_grant=g, and go to START.
REQ-023 START: eng_start=1 for exactly one cycle, wait counter cleared, next state WAIT.
REQ-024 eng_x SHALL equal x_reg continuously from START through WAIT.
REQ-025 WAIT: eng_rdy is sampled each cycle; on the first cycle with eng_rdy=1, root_reg=eng_root, err_reg=0, next state RESP.
REQ-026 eng_rdy SHALL be ignored in START and in IDLE (the stale done flag of a previous run).
REQ-027 WAIT: the counter increments each cycle without eng_rdy; when it reaches TIMEOUT-1, the block SHALL set root_reg=0, err_reg=1 and err_sticky=1, then go to RESP.
REQ-028 If eng_rdy=1 in the same cycle the timeout is hit, eng_rdy SHALL win (normal result, no error).
REQ-029 RESP: resp_valid=1 with resp_id=id_reg, resp_root=root_reg, resp_err=err_reg, all held stable until resp_ready=1.
REQ-030 RESP with resp_ready=1 SHALL return the FSM to IDLE; a new grant is possible in that next IDLE cycle, not in the RESP cycle.
REQ-031 resp_valid SHALL rise exactly one cycle after the cycle in which eng_rdy is sampled high in WAIT.
REQ-032 Requests arriving while busy SHALL be held off (req_ready=0), not dropped; requester-side hold is mandatory.
REQ-033 Throughput: at most one outstanding operation; there is no queue.

Reset
REQ-034 On reset assertion, asynchronously: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_root=0, resp_err=0, eng_start=0, eng_x=0, busy=0, err_sticky=0, last_grant=NREQ-1 (so requester 0 has first priority).
REQ-035 Reset mid-operation SHALL abandon the in-flight request without producing a response; the requester must re-request.

Verification
REQ-036 Single request: req_valid=0001, x=1000000; engine model asserts rdy 16 cycles after eng_start -> one eng_start pulse, then resp_valid with id=0, root=1000, err=0, exactly one cycle after rdy.
REQ-037 Round robin: req_valid=1111 held constant -> grant order 0,1,2,3,0; each grant only after the previous response is accepted.
REQ-038 Boundaries: x=0 -> root=0; x=0xFFFFFFFF -> root=65535; x=15 -> root=3.
REQ-039 Back-pressure: resp_ready=0 for 10 cycles -> resp_valid, resp_id and resp_root stable; req_ready=0 throughout.
REQ-040 Timeout: engine never asserts rdy -> resp_valid TIMEOUT+1 cycles after START with err=1, root=0, and err_sticky=1; the next normal request completes with err=0 while err_sticky stays 1.
REQ-041 Reset mid-WAIT: reset asserted 5 cycles after START -> no resp_valid; after release, req_valid=0010 is granted first.
